// File: rtl/cla_subtractor_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cla_subtractor_pipe_pkg
// Shared constants and types for the two-stage borrow-lookahead subtractor.
//   DEFAULT_WIDTH  : default operand width of the pipeline
//   HALF           : width of one pipeline slice at the default width
//   s1_payload_t   : stage-1 register contents at the default width
//                    (low difference, mid borrow, upper operand halves)
//   width_ok()     : legality test for the WIDTH parameter (even, >= 4)
// -----------------------------------------------------------------------------
package cla_subtractor_pipe_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int HALF          = DEFAULT_WIDTH / 2;

   typedef struct packed {
      logic [HALF-1:0] lo_diff;
      logic            mid_borrow;
      logic [HALF-1:0] a_hi;
      logic [HALF-1:0] b_hi;
   } s1_payload_t;

   function automatic bit width_ok(input int w);
      return (w >= 4) && ((w % 2) == 0);
   endfunction

endpackage

// File: rtl/cla_subtractor_pipe_bla_slice.sv
// -----------------------------------------------------------------------------
// bla_slice
// Combinational N-bit borrow-lookahead subtractor: d = x - y - bin.
//   x    : minuend slice
//   y    : subtrahend slice
//   bin  : borrow into bit 0
//   d    : difference slice
//   bout : borrow out of bit N-1
// Borrows are formed with a Kogge-Stone parallel prefix over the per-bit
// (generate, propagate) pairs, so depth grows with log2(N), not N.
// -----------------------------------------------------------------------------
module bla_slice
   import cla_subtractor_pipe_pkg::*;
#(
   parameter int N = HALF
)(
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         bin,
   output logic [N-1:0] d,
   output logic         bout
);

   localparam int LEVELS = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]              p;     // borrow passes through this bit
   logic [N-1:0]              g;     // this bit creates a borrow
   logic [LEVELS:0][N-1:0]    gk;    // group generate over bits [i:0] after each level
   logic [LEVELS:0][N-1:0]    pk;    // group propagate over bits [i:0] after each level
   logic [N:0]                br;    // br[i] = borrow into bit i

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign p[gi] = ~(x[gi] ^ y[gi]);
         assign g[gi] = ~x[gi] & y[gi];
         assign d[gi] = x[gi] ^ y[gi] ^ br[gi];
      end
   endgenerate

   always_comb begin
      gk    = '0;
      pk    = '0;
      br    = '0;
      gk[0] = g;
      pk[0] = p;
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < N; i++) begin
            if (i >= (1 << l)) begin
               gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i - (1 << l)]);
               pk[l+1][i] = pk[l][i] & pk[l][i - (1 << l)];
            end else begin
               gk[l+1][i] = gk[l][i];
               pk[l+1][i] = pk[l][i];
            end
         end
      end
      // The incoming borrow enters every prefix through its group propagate.
      br[0] = bin;
      for (int i = 0; i < N; i++) begin
         br[i+1] = gk[LEVELS][i] | (pk[LEVELS][i] & bin);
      end
   end

   assign bout = br[N];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// cla_subtractor_pipe
// Two-stage pipelined subtractor computing (a - b - bin) mod 2^WIDTH with
// valid/ready handshakes on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result beat handshake
//   diff                 : difference
//   bout                 : unsigned borrow-out (a < b + bin)
//   ovf                  : two's-complement signed overflow
//   zero                 : diff == 0
// Stage 1 resolves the low half and the mid borrow; stage 2 resolves the upper
// half from the registered mid borrow. All result outputs come straight from
// stage-2 registers.
// -----------------------------------------------------------------------------
module cla_subtractor_pipe
   import cla_subtractor_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = WIDTH / 2;

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("cla_subtractor_pipe: WIDTH must be even and at least 4");
      end
   endgenerate

   // Same shape as s1_payload_t, sized from this instance's WIDTH.
   typedef struct packed {
      logic [SW-1:0] lo_diff;
      logic          mid_borrow;
      logic [SW-1:0] a_hi;
      logic [SW-1:0] b_hi;
   } stage1_t;

   stage1_t          s1_next;
   stage1_t          s1_reg;
   logic             s1_valid_reg;
   logic             s2_valid_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             bout_reg;
   logic             ovf_reg;
   logic             zero_reg;

   logic [SW-1:0]    lo_d;
   logic             lo_b;
   logic [SW-1:0]    hi_d;
   logic             hi_b;
   logic [WIDTH-1:0] diff_next;
   logic             ovf_next;
   logic             zero_next;

   logic             in_fire;
   logic             s2_ready;
   logic             s1_advance;

   // ---------------- handshake ----------------
   // A stage can take new data when it is empty or its contents leave this
   // cycle; this lets a full pipe accept, shift and emit in one cycle.
   assign s2_ready   = !s2_valid_reg || out_ready;
   assign s1_advance = s1_valid_reg && s2_ready;
   assign in_ready   = !s1_valid_reg || s1_advance;
   assign in_fire    = in_valid && in_ready;

   // ---------------- stage 1: low half ----------------
   bla_slice #(.N(SW)) u_lo (
      .x    (a[SW-1:0]),
      .y    (b[SW-1:0]),
      .bin  (bin),
      .d    (lo_d),
      .bout (lo_b)
   );

   always_comb begin
      s1_next            = '0;
      s1_next.lo_diff    = lo_d;
      s1_next.mid_borrow = lo_b;
      s1_next.a_hi       = a[WIDTH-1:SW];
      s1_next.b_hi       = b[WIDTH-1:SW];
   end

   // ---------------- stage 2: upper half ----------------
   bla_slice #(.N(SW)) u_hi (
      .x    (s1_reg.a_hi),
      .y    (s1_reg.b_hi),
      .bin  (s1_reg.mid_borrow),
      .d    (hi_d),
      .bout (hi_b)
   );

   always_comb begin
      diff_next = {hi_d, s1_reg.lo_diff};
      // Overflow only when operand signs differ and the result sign departs
      // from the minuend's sign.
      ovf_next  = (s1_reg.a_hi[SW-1] != s1_reg.b_hi[SW-1]) &&
                  (hi_d[SW-1] != s1_reg.a_hi[SW-1]);
      zero_next = (diff_next == '0);
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_reg       <= '0;
         s2_valid_reg <= 1'b0;
         diff_reg     <= '0;
         bout_reg     <= 1'b0;
         ovf_reg      <= 1'b0;
         zero_reg     <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_reg       <= s1_next;
         end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
         end

         if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
         end

         // Result registers only load on a real move, so a stalled result
         // stays frozen while out_ready is low.
         if (s1_advance) begin
            diff_reg <= diff_next;
            bout_reg <= hi_b;
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign diff      = diff_reg;
   assign bout      = bout_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;

endmodule
